// File: rtl/alu_control_seq.sv
// ALU control decoder with a start/stall sequencer for the RV32M multiply/divide unit.
// Optional feature macro: ALU_CTRL_DIV_EN (sequences DIV/DIVU/REM/REMU; otherwise they decode as illegal).
module alu_control_seq #(
  parameter int OP_W       = 4,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      ALU_Op_i,
  input  logic [2:0]      funct3_i,
  output logic [OP_W-1:0] ALU_Operation_o,
  output logic            mdu_start_o,
  output logic [2:0]      mdu_op_o,
  output logic            stall_o,
  output logic            done_o,
  output logic            illegal_o
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_LUI  = 4'b0001;
  localparam logic [3:0] C_OR   = 4'b0010;
  localparam logic [3:0] C_SLL  = 4'b0011;
  localparam logic [3:0] C_SRL  = 4'b0100;
  localparam logic [3:0] C_SUB  = 4'b0101;
  localparam logic [3:0] C_AND  = 4'b0111;
  localparam logic [3:0] C_XOR  = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1001;
  localparam logic [3:0] C_SLT  = 4'b1010;
  localparam logic [3:0] C_SLTU = 4'b1011;
  localparam logic [3:0] C_MDU  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_mdu_op;

  logic [3:0]       w_dec_code;
  logic             w_dec_ill;
  logic             w_is_mop;
  logic             w_mop_ok;
  logic             w_accept;
  logic [CNT_W-1:0] w_lat;

  logic [3:0]       w_code;
  logic             w_illegal;
  logic             w_stall;
  logic             w_start;
  logic             w_done;

  assign w_is_mop = (ALU_Op_i == 3'b000) && (funct7_i == 7'b0000001);

`ifdef ALU_CTRL_DIV_EN
  assign w_mop_ok = w_is_mop;
  assign w_lat    = funct3_i[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
`else
  assign w_mop_ok = w_is_mop && !funct3_i[2];
  assign w_lat    = CNT_W'(MUL_CYCLES - 1);
`endif

  // Reset gates acceptance so stall/start fall immediately even while an M op is presented.
  assign w_accept = (r_state == S_IDLE) && valid_i && w_mop_ok && !reset;

  always_comb begin
    w_dec_code = C_ADD;
    w_dec_ill  = 1'b0;
    case (ALU_Op_i)
      3'b000: begin
        if (funct7_i == 7'b0000000) begin
          case (funct3_i)
            3'b000:  w_dec_code = C_ADD;
            3'b001:  w_dec_code = C_SLL;
            3'b010:  w_dec_code = C_SLT;
            3'b011:  w_dec_code = C_SLTU;
            3'b100:  w_dec_code = C_XOR;
            3'b101:  w_dec_code = C_SRL;
            3'b110:  w_dec_code = C_OR;
            3'b111:  w_dec_code = C_AND;
            default: w_dec_code = C_ADD;
          endcase
        end else if ((funct7_i == 7'b0100000) && (funct3_i == 3'b000)) begin
          w_dec_code = C_SUB;
        end else if ((funct7_i == 7'b0100000) && (funct3_i == 3'b101)) begin
          w_dec_code = C_SRA;
        end else if (w_is_mop) begin
          w_dec_ill = !w_mop_ok;
        end else begin
          w_dec_ill = 1'b1;
        end
      end
      3'b001: begin
        case (funct3_i)
          3'b000:  w_dec_code = C_ADD;
          3'b010:  w_dec_code = C_SLT;
          3'b011:  w_dec_code = C_SLTU;
          3'b100:  w_dec_code = C_XOR;
          3'b110:  w_dec_code = C_OR;
          3'b111:  w_dec_code = C_AND;
          3'b001: begin
            if (funct7_i == 7'b0000000) w_dec_code = C_SLL;
            else                        w_dec_ill  = 1'b1;
          end
          3'b101: begin
            if (funct7_i == 7'b0000000)      w_dec_code = C_SRL;
            else if (funct7_i == 7'b0100000) w_dec_code = C_SRA;
            else                             w_dec_ill  = 1'b1;
          end
          default: w_dec_ill = 1'b1;
        endcase
      end
      3'b010:  w_dec_code = C_LUI;
      3'b011:  w_dec_code = C_ADD;
      3'b100:  w_dec_code = C_SUB;
      default: w_dec_ill  = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code      = 4'b0000;
    w_illegal   = 1'b0;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = w_lat;
          w_code      = C_MDU;
          w_stall     = 1'b1;
          w_start     = 1'b1;
        end else if (valid_i) begin
          w_code    = w_dec_code;
          w_illegal = w_dec_ill;
        end else begin
          w_code = 4'b0000;
        end
      end
      S_BUSY: begin
        w_code  = C_MDU;
        w_stall = 1'b1;
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        w_code      = C_MDU;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_mdu_op <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) r_mdu_op <= funct3_i;
    end
  end

  assign ALU_Operation_o = OP_W'(w_code);
  assign mdu_start_o     = w_start;
  assign mdu_op_o        = r_mdu_op;
  assign stall_o         = w_stall;
  assign done_o          = w_done;
  assign illegal_o       = w_illegal;

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomized self-checking bench for alu_control_seq against a rule-level decode/latency model.
module tb_alu_control_seq;

  localparam int MUL_N = 2;
  localparam int DIV_N = 32;
`ifdef ALU_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic [6:0] funct7_i;
  logic [2:0] ALU_Op_i;
  logic [2:0] funct3_i;
  logic [3:0] ALU_Operation_o;
  logic       mdu_start_o;
  logic [2:0] mdu_op_o;
  logic       stall_o;
  logic       done_o;
  logic       illegal_o;
  logic [7:0] obs;

  int checks = 0;
  int errors = 0;

  alu_control_seq #(.OP_W(4), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .funct7_i(funct7_i),
    .ALU_Op_i(ALU_Op_i), .funct3_i(funct3_i), .ALU_Operation_o(ALU_Operation_o),
    .mdu_start_o(mdu_start_o), .mdu_op_o(mdu_op_o), .stall_o(stall_o),
    .done_o(done_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  assign obs = {ALU_Operation_o, mdu_start_o, stall_o, done_o, illegal_o};

  // Returns {illegal, code} for a non-accepted selector.
  function automatic logic [4:0] ref_dec(input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3);
    logic [3:0] base [0:7];
    base = '{4'b0000, 4'b0011, 4'b1010, 4'b1011, 4'b1000, 4'b0100, 4'b0010, 4'b0111};
    case (op)
      3'd0: begin
        if (f7 == 7'd0)                       return {1'b0, base[f3]};
        else if (f7 == 7'h20 && f3 == 3'd0)   return {1'b0, 4'b0101};
        else if (f7 == 7'h20 && f3 == 3'd5)   return {1'b0, 4'b1001};
        else                                  return {1'b1, 4'b0000};
      end
      3'd1: begin
        if (f3 == 3'd1)      return (f7 == 7'd0) ? {1'b0, 4'b0011} : {1'b1, 4'b0000};
        else if (f3 == 3'd5) return (f7 == 7'd0) ? {1'b0, 4'b0100} :
                                    (f7 == 7'h20) ? {1'b0, 4'b1001} : {1'b1, 4'b0000};
        else                 return {1'b0, base[f3]};
      end
      3'd2:    return {1'b0, 4'b0001};
      3'd3:    return {1'b0, 4'b0000};
      3'd4:    return {1'b0, 4'b0101};
      default: return {1'b1, 4'b0000};
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3);
    valid_i  = v;
    ALU_Op_i = op;
    funct7_i = f7;
    funct3_i = f3;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom_range(0, 7)));
    #2;
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_outputs obs=%b exp=%b", obs, 8'h00); end
    checks++;
    if (mdu_op_o !== 3'b000) begin errors++; $display("FAIL reset_mdu_op got=%b exp=000", mdu_op_o); end
    @(negedge clk);
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_decode(input int count);
    logic [2:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       v;
    logic [4:0] r;
    logic [7:0] exp;
    for (int i = 0; i < count; i++) begin
      op = 3'($urandom_range(0, 7));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      if (op == 3'd0 && f7 == 7'd1 && (DIV_EN || !f3[2])) f7 = 7'h00;
      v = ($urandom_range(0, 7) != 0);
      drive(v, op, f7, f3);
      @(negedge clk);
      r   = ref_dec(op, f7, f3);
      exp = v ? {r[3:0], 3'b000, r[4]} : 8'h00;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL decode v=%b op=%b f7=%b f3=%b obs=%b exp=%b", v, op, f7, f3, obs, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_r_special();
    drive(1'b1, 3'b000, 7'b0100000, 3'b101);
    @(negedge clk);
    checks++;
    if (obs !== {4'b1001, 4'b0000}) begin errors++; $display("FAIL r_sra obs=%b exp=%b", obs, {4'b1001, 4'b0000}); end
    next_cycle();
    drive(1'b1, 3'b000, 7'b0100000, 3'b111);
    @(negedge clk);
    checks++;
    if (obs !== {4'b0000, 4'b0001}) begin errors++; $display("FAIL r_illegal obs=%b exp=%b", obs, {4'b0000, 4'b0001}); end
    next_cycle();
  endtask

  // Drives an M op at cycle T and checks every cycle up to T+n+1 (and IDLE after, unless chaining).
  task automatic run_mop(input logic [2:0] f3, input int n, input bit toggle, input bit chain, input logic [2:0] chain_f3);
    logic [7:0] exp;
    drive(1'b1, 3'b000, 7'b0000001, f3);
    @(negedge clk);
    checks++;
    if (obs !== 8'b1100_1100) begin errors++; $display("FAIL mop_start f3=%b obs=%b exp=%b", f3, obs, 8'b1100_1100); end
    next_cycle();
    for (int k = 1; k <= n + 1; k++) begin
      if (k == n + 1 && chain)
        drive(1'b1, 3'b000, 7'b0000001, chain_f3);
      else if (toggle)
        drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      else
        drive(1'b0, 3'b000, 7'b0000000, 3'b000);
      @(negedge clk);
      exp = {4'b1100, 1'b0, (k <= n), (k == n + 1), 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mop_cycle f3=%b k=%0d obs=%b exp=%b", f3, k, obs, exp); end
      checks++;
      if (mdu_op_o !== f3) begin errors++; $display("FAIL mop_op k=%0d got=%b exp=%b", k, mdu_op_o, f3); end
      next_cycle();
    end
    if (!chain) begin
      drive(1'b0, 3'b000, 7'b0000000, 3'b000);
      @(negedge clk);
      checks++;
      if (obs !== 8'h00) begin errors++; $display("FAIL mop_idle f3=%b obs=%b exp=%b", f3, obs, 8'h00); end
      next_cycle();
    end
  endtask

  task automatic test_mul();
    run_mop(3'b000, MUL_N, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) run_mop(3'($urandom_range(0, 3)), MUL_N, 1'b1, 1'b0, 3'b000);
  endtask

  task automatic test_div();
`ifdef ALU_CTRL_DIV_EN
    run_mop(3'b101, DIV_N, 1'b1, 1'b0, 3'b000);
    run_mop(3'($urandom_range(4, 7)), DIV_N, 1'b1, 1'b0, 3'b000);
`else
    for (int f = 4; f < 8; f++) begin
      drive(1'b1, 3'b000, 7'b0000001, 3'(f));
      @(negedge clk);
      checks++;
      if (obs !== 8'b0000_0001) begin errors++; $display("FAIL div_disabled f3=%0d obs=%b exp=%b", f, obs, 8'b0000_0001); end
      next_cycle();
    end
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL div_disabled_idle obs=%b exp=%b", obs, 8'h00); end
    next_cycle();
`endif
  endtask

  task automatic test_back_to_back();
    run_mop(3'b001, MUL_N, 1'b0, 1'b1, 3'b000);
    run_mop(3'b000, MUL_N, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_reset_midflight();
`ifdef ALU_CTRL_DIV_EN
    int kr = 10;
    logic [2:0] f3 = 3'b100;
`else
    int kr = 1;
    logic [2:0] f3 = 3'b011;
`endif
    drive(1'b1, 3'b000, 7'b0000001, f3);
    next_cycle();
    for (int k = 1; k < kr; k++) next_cycle();
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL midflight_busy stall=%b exp=1", stall_o); end
    reset = 1'b1;
    #1;
    checks++;
    if ({mdu_start_o, stall_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL midflight_reset start/stall/done=%b exp=000", {mdu_start_o, stall_o, done_o});
    end
    checks++;
    if (mdu_op_o !== 3'b000) begin errors++; $display("FAIL midflight_mdu_op got=%b exp=000", mdu_op_o); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL midflight_idle obs=%b exp=%b", obs, 8'h00); end
    next_cycle();
    run_mop(3'b000, MUL_N, 1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_decode(200);
    test_r_special();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_midflight();
    test_decode(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
